// File: rtl/ahb_split_ctrl_if.sv
// ahb_split_ctrl_if: response-bus taps into the SPLIT controller and the mask/status it returns to the arbiter
`ifndef NUM_MASTERS
`define NUM_MASTERS 4
`endif
interface ahb_split_ctrl_if #(parameter int NUM_MASTERS = `NUM_MASTERS);
    localparam int MW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;
    logic [MW-1:0]          Hmaster;
    logic                   Hready;
    logic [1:0]             Hresp;
    logic [NUM_MASTERS-1:0] Hsplit;
    logic [NUM_MASTERS-1:0] Hreq_mask;
    logic [MW-1:0]          Hmaster_data;
    logic                   Hall_split;
    logic [NUM_MASTERS-1:0] split_timeout;
    logic                   prot_err;
    modport slave (
        input  Hmaster, Hready, Hresp, Hsplit,
        output Hreq_mask, Hmaster_data, Hall_split, split_timeout, prot_err
    );
    modport master (
        output Hmaster, Hready, Hresp, Hsplit,
        input  Hreq_mask, Hmaster_data, Hall_split, split_timeout, prot_err
    );
endinterface

// File: rtl/ahb_split_ctrl.sv
// ahb_split_ctrl: masks masters that received a SPLIT response until resumed via Hsplit or released by a watchdog
`ifndef NUM_MASTERS
`define NUM_MASTERS 4
`endif
module ahb_split_ctrl #(
    parameter int NUM_MASTERS   = `NUM_MASTERS,
    parameter int SPLIT_TIMEOUT = 256
) (
    input  logic               Hclk,
    input  logic               Hreset,
    ahb_split_ctrl_if.slave    bus
);
    localparam int MW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = SPLIT_TIMEOUT > 0 ? $clog2(SPLIT_TIMEOUT + 1) : 1;
    localparam bit WD = SPLIT_TIMEOUT != 0;
    localparam logic [CW-1:0] LAST = CW'(SPLIT_TIMEOUT > 0 ? SPLIT_TIMEOUT - 1 : 0);

    typedef enum logic {FREE, SPLIT} st_t;

    st_t                    st  [NUM_MASTERS];
    logic [CW-1:0]          cnt [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] mask, tout;
    logic [MW-1:0]          md;
    logic                   prev_split, perr, split_now;

    assign split_now = bus.Hready && bus.Hresp == 2'b11;

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            prev_split <= 1'b0;
            perr       <= 1'b0;
            md         <= '0;
            mask       <= '0;
            tout       <= '0;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                st[i]  <= FREE;
                cnt[i] <= '0;
            end
        end else begin
            prev_split <= !bus.Hready && bus.Hresp == 2'b11;
            perr       <= split_now && !prev_split;
            if (bus.Hready) md <= bus.Hmaster;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                tout[i] <= 1'b0;
                // md still holds the data-phase owner of the SPLIT being completed
                if (split_now && prev_split && md == MW'(i)) begin
                    st[i]   <= SPLIT;
                    mask[i] <= 1'b1;
                    cnt[i]  <= '0;
                end else if (st[i] == SPLIT) begin
                    if (bus.Hsplit[i] || (WD && cnt[i] == LAST)) begin
                        st[i]   <= FREE;
                        mask[i] <= 1'b0;
                        cnt[i]  <= '0;
                        tout[i] <= !bus.Hsplit[i];
                    end else if (cnt[i] != '1) begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.Hreq_mask     = mask;
    assign bus.Hmaster_data  = md;
    assign bus.Hall_split    = &mask;
    assign bus.split_timeout = tout;
    assign bus.prot_err      = perr;
endmodule

// File: tb/tb_ahb_split_ctrl.sv
// tb_ahb_split_ctrl: directed vector table plus hand sequences for watchdog, precedence and reset corners
module tb_ahb_split_ctrl;
    logic Hclk = 1'b0;
    logic Hreset = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    ahb_split_ctrl_if #(.NUM_MASTERS(4)) bus ();
    ahb_split_ctrl #(.NUM_MASTERS(4), .SPLIT_TIMEOUT(16)) dut (.Hclk(Hclk), .Hreset(Hreset), .bus(bus));

    always #5 Hclk = ~Hclk;

    typedef struct {
        logic       rst;
        logic [1:0] hm;
        logic       rdy;
        logic [1:0] resp;
        logic [3:0] hs;
        logic [3:0] m;
        logic [1:0] md;
        logic       all;
        logic [3:0] to;
        logic       perr;
    } vec_t;

    vec_t tv [16];

    task automatic drive(input logic rst, input logic [1:0] hm, input logic rdy, input logic [1:0] resp, input logic [3:0] hs);
        Hreset      = rst;
        bus.Hmaster = hm;
        bus.Hready  = rdy;
        bus.Hresp   = resp;
        bus.Hsplit  = hs;
    endtask

    task automatic step();
        @(posedge Hclk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] m, input logic [1:0] md, input logic all,
                         input logic [3:0] to, input logic perr);
        nvec++;
        if ({bus.Hreq_mask, bus.Hmaster_data, bus.Hall_split, bus.split_timeout, bus.prot_err} !== {m, md, all, to, perr}) begin
            nerr++;
            $display("FAIL %s: got mask=%b md=%0d all=%b to=%b perr=%b, want mask=%b md=%0d all=%b to=%b perr=%b",
                     name, bus.Hreq_mask, bus.Hmaster_data, bus.Hall_split, bus.split_timeout, bus.prot_err,
                     m, md, all, to, perr);
        end
    endtask

    task automatic check_mask(input string name, input logic [3:0] m, input logic all, input logic [3:0] to);
        nvec++;
        if ({bus.Hreq_mask, bus.Hall_split, bus.split_timeout} !== {m, all, to}) begin
            nerr++;
            $display("FAIL %s: got mask=%b all=%b to=%b, want mask=%b all=%b to=%b",
                     name, bus.Hreq_mask, bus.Hall_split, bus.split_timeout, m, all, to);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        nvec++;
        if (got != want) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic split_master(input logic [1:0] m);
        drive(0, m, 1, 2'b00, 4'b0000); step();
        drive(0, m, 0, 2'b11, 4'b0000); step();
        drive(0, m, 1, 2'b11, 4'b0000); step();
        drive(0, m, 1, 2'b00, 4'b0000);
    endtask

    task automatic measure(input int idx, output int n, output logic [3:0] to_seen);
        n = 0;
        for (int k = 0; k < 40 && bus.Hreq_mask[idx]; k++) begin
            n++;
            step();
        end
        to_seen = bus.split_timeout;
    endtask

    initial begin
        int         n;
        logic [3:0] to_seen;
        //         rst hm  rdy resp   hs       mask     md  all to       perr
        tv[0]  = '{1, 0, 1, 2'b00, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0};
        tv[1]  = '{0, 2, 1, 2'b00, 4'b0000, 4'b0000, 2, 0, 4'b0000, 0};
        tv[2]  = '{0, 0, 0, 2'b11, 4'b0000, 4'b0000, 2, 0, 4'b0000, 0};
        tv[3]  = '{0, 0, 1, 2'b11, 4'b0000, 4'b0100, 0, 0, 4'b0000, 0};
        tv[4]  = '{0, 0, 1, 2'b00, 4'b0100, 4'b0000, 0, 0, 4'b0000, 0};
        tv[5]  = '{0, 0, 1, 2'b00, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0};
        tv[6]  = '{0, 1, 1, 2'b11, 4'b0000, 4'b0000, 1, 0, 4'b0000, 1};
        tv[7]  = '{0, 1, 1, 2'b00, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0};
        tv[8]  = '{0, 1, 1, 2'b00, 4'b1111, 4'b0000, 1, 0, 4'b0000, 0};
        tv[9]  = '{0, 3, 1, 2'b00, 4'b0000, 4'b0000, 3, 0, 4'b0000, 0};
        tv[10] = '{0, 0, 0, 2'b01, 4'b0000, 4'b0000, 3, 0, 4'b0000, 0};
        tv[11] = '{0, 0, 1, 2'b01, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0};
        tv[12] = '{0, 1, 1, 2'b00, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0};
        tv[13] = '{0, 2, 0, 2'b11, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0};
        tv[14] = '{0, 0, 1, 2'b11, 4'b0010, 4'b0010, 0, 0, 4'b0000, 0};
        tv[15] = '{0, 0, 1, 2'b00, 4'b0010, 4'b0000, 0, 0, 4'b0000, 0};

        for (int v = 0; v < 16; v++) begin
            drive(tv[v].rst, tv[v].hm, tv[v].rdy, tv[v].resp, tv[v].hs);
            step();
            check($sformatf("vec%0d", v), tv[v].m, tv[v].md, tv[v].all, tv[v].to, tv[v].perr);
        end

        // watchdog expiry on master 1
        split_master(1);
        check_mask("wd_enter", 4'b0010, 0, 4'b0000);
        measure(1, n, to_seen);
        check_int("wd_duration", n, 16);
        check_mask("wd_pulse", 4'b0000, 0, 4'b0010);
        step();
        check_mask("wd_pulse_end", 4'b0000, 0, 4'b0000);

        // resume coinciding with the expiry edge
        split_master(1);
        repeat (15) step();
        check_mask("rx_before", 4'b0010, 0, 4'b0000);
        drive(0, 0, 1, 2'b00, 4'b0010);
        step();
        check_mask("rx_resume", 4'b0000, 0, 4'b0000);
        drive(0, 0, 1, 2'b00, 4'b0000);
        step();
        check_mask("rx_no_pulse", 4'b0000, 0, 4'b0000);

        // all masters split
        split_master(0);
        check_mask("all_m0", 4'b0001, 0, 4'b0000);
        split_master(1);
        check_mask("all_m1", 4'b0011, 0, 4'b0000);
        split_master(2);
        check_mask("all_m2", 4'b0111, 0, 4'b0000);
        split_master(3);
        check_mask("all_m3", 4'b1111, 1, 4'b0000);
        drive(0, 0, 1, 2'b00, 4'b1000);
        step();
        check_mask("all_resume3", 4'b0111, 0, 4'b0000);
        drive(0, 0, 1, 2'b00, 4'b0111);
        step();
        check_mask("all_clear", 4'b0000, 0, 4'b0000);

        // reset in the middle of a split
        split_master(0);
        split_master(3);
        check_mask("rst_pre", 4'b1001, 0, 4'b0000);
        drive(0, 2, 1, 2'b00, 4'b0000);
        step();
        step();
        check("rst_pre_md", 4'b1001, 2, 0, 4'b0000, 0);
        drive(1, 2, 1, 2'b11, 4'b0000);
        step();
        check("rst_all_zero", 4'b0000, 0, 0, 4'b0000, 0);
        split_master(0);
        check_mask("rst_resplit", 4'b0001, 0, 4'b0000);
        measure(0, n, to_seen);
        check_int("rst_wd_duration", n, 16);
        check_mask("rst_wd_pulse", 4'b0000, 0, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
